// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully-connected layer sequencer.
package fc_pkg;

  localparam int DATA_W    = 32;
  localparam int FRAC_BITS = 16;

  typedef logic signed [DATA_W-1:0] q16_t;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    DRAIN,
    ACT,
    OUT,
    FIN
  } fc_state_e;

  // Clamp a wide Q16.16 accumulator into the signed 32-bit range.
  function automatic q16_t sat32(input logic signed [63:0] acc);
    if (acc > 64'sh0000_0000_7FFF_FFFF)
      return 32'sh7FFF_FFFF;
    else if (acc < -64'sh0000_0000_8000_0000)
      return 32'sh8000_0000;
    else
      return acc[31:0];
  endfunction

endpackage

// File: rtl/fc_mac_unit.sv
// Q16.16 multiply / rescale / accumulate with bias load and synchronous clear.
module fc_mac_unit
  import fc_pkg::*;
#(
  parameter int ACC_W     = 48,
  parameter int FRAC_BITS = 16
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    load,
  input  logic                    accum,
  input  q16_t                    a,
  input  q16_t                    b,
  input  q16_t                    bias,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [63:0]      prod_full;
  logic signed [ACC_W-1:0] prod;

  // The true product of two 32-bit signed values always fits in 64 bits.
  assign prod_full = 64'(a) * 64'(b);
  assign prod      = ACC_W'(prod_full >>> FRAC_BITS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc <= '0;
    else if (clr)
      acc <= '0;
    else if (load)
      acc <= ACC_W'(bias) + prod;
    else if (accum)
      acc <= acc + prod;
  end

endmodule

// File: rtl/fc_layer_sequencer.sv
// One fully-connected layer: per-neuron MAC walk, bias, saturation, optional ReLU.
// FC_SEQ_RELU_EN defined clamps negative results to zero (hidden layers).
module fc_layer_sequencer
  import fc_pkg::*;
#(
  parameter int NUM_IN    = 784,
  parameter int NUM_OUT   = 10,
  parameter int FRAC_BITS = fc_pkg::FRAC_BITS,
  parameter int ACC_W     = 48,
  parameter int WADDR_W   = 14,
  localparam int IW = (NUM_IN  > 1) ? $clog2(NUM_IN)  : 1,
  localparam int OW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [IW-1:0]      in_index,
  input  logic [31:0]        in_data,
  output logic [WADDR_W-1:0] w_index,
  input  logic [31:0]        w_data,
  output logic [OW-1:0]      b_index,
  input  logic [31:0]        b_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OW-1:0]      out_index,
  output logic [31:0]        out_data
);

  fc_state_e               state;
  logic                    data_cyc, first, mac_clr;
  logic signed [ACC_W-1:0] acc;
  q16_t                    sat_v, act_v;

  // ROM data lags the index by one cycle, so MAC i=0 carries nothing useful.
  assign data_cyc = (state == MAC && in_index != '0) || state == DRAIN;
  assign first    = (state == MAC && in_index == IW'(1)) || (state == DRAIN && NUM_IN == 1);
  assign mac_clr  = (state == IDLE);

  fc_mac_unit #(.ACC_W(ACC_W), .FRAC_BITS(FRAC_BITS)) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mac_clr),
    .load  (first),
    .accum (data_cyc && !first),
    .a     (in_data),
    .b     (w_data),
    .bias  (b_data),
    .acc   (acc)
  );

  always_comb begin
    sat_v = sat32(64'(acc));
`ifdef FC_SEQ_RELU_EN
    act_v = sat_v[31] ? '0 : sat_v;
`else
    act_v = sat_v;
`endif
  end

  // b_index doubles as the neuron counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_index  <= '0;
      w_index   <= '0;
      b_index   <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= MAC;
          busy     <= 1'b1;
          in_index <= '0;
          w_index  <= '0;
          b_index  <= '0;
        end
        MAC: begin
          if (in_index == IW'(NUM_IN - 1)) begin
            state <= DRAIN;
          end else begin
            in_index <= in_index + 1'b1;
            w_index  <= w_index + 1'b1;
          end
        end
        DRAIN: state <= ACT;
        ACT: begin
          out_data  <= act_v;
          out_index <= b_index;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          if (b_index == OW'(NUM_OUT - 1)) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= MAC;
            b_index  <= b_index + 1'b1;
            in_index <= '0;
            w_index  <= w_index + 1'b1;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
